// File: rtl/dram_access_arbiter.sv
// Shares one DRAM sequencer port between two round-robin clients and a CBR refresh scheduler.
// Define ARB_TIMEOUT_EN to add a BUSY watchdog that aborts accesses lacking mem_ack.
module dram_access_arbiter #(
  parameter int unsigned REF_INTERVAL = 156,
  parameter int unsigned DEBT_MAX     = 8,
  parameter int unsigned URGENT       = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_wdata,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        mem_req,
  output logic        mem_ref,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [3:0]  ref_debt,
  output logic        ref_ovf,
  output logic        err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SRC_C0 = 2'd0, SRC_C1 = 2'd1, SRC_REF = 2'd2, SRC_NONE = 2'd3} src_t;

  state_t     state_r, state_s;
  src_t       sel_s, grant_r;
  logic [7:0] interval_r, timer_r;
  logic       last_grant_r;
  logic       tick_s, ref_start_s, abort_s;

  assign tick_s      = (interval_r != 8'd0) && (timer_r == 8'd0);
  assign ref_start_s = (state_r == IDLE) && (sel_s == SRC_REF);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] busy_cnt_r;

  // Counts cycles spent waiting in BUSY; cleared everywhere else
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt_r <= {CW{1'b0}};
    end else if (state_r == BUSY) begin
      busy_cnt_r <= busy_cnt_r + CW'(1);
    end else begin
      busy_cnt_r <= {CW{1'b0}};
    end
  end

  assign abort_s = (state_r == BUSY) && !mem_ack && (busy_cnt_r == CW'(TIMEOUT - 1));
`else
  logic [31:0] unused_timeout_s;
  assign unused_timeout_s = TIMEOUT;
  assign abort_s = 1'b0;
`endif

  // Refresh interval register and countdown timer
  always_ff @(posedge clk) begin
    if (rst) begin
      interval_r <= 8'(REF_INTERVAL);
      timer_r    <= 8'(REF_INTERVAL - 1);
    end else if (cfg_we) begin
      interval_r <= cfg_wdata;
      timer_r    <= cfg_wdata - 8'd1;
    end else if (interval_r == 8'd0) begin
      timer_r    <= timer_r;
    end else if (timer_r == 8'd0) begin
      timer_r    <= interval_r - 8'd1;
    end else begin
      timer_r    <= timer_r - 8'd1;
    end
  end

  // Refresh debt: ticks add, refresh starts subtract, saturation raises the sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_debt <= 4'd0;
      ref_ovf  <= 1'b0;
    end else begin
      if (tick_s && !ref_start_s) begin
        if (ref_debt != 4'(DEBT_MAX)) begin
          ref_debt <= ref_debt + 4'd1;
        end
      end else if (!tick_s && ref_start_s) begin
        ref_debt <= ref_debt - 4'd1;
      end
      if (cfg_we) begin
        ref_ovf <= 1'b0;
      end else if (tick_s && !ref_start_s && (ref_debt == 4'(DEBT_MAX))) begin
        ref_ovf <= 1'b1;
      end
    end
  end

  // IDLE arbitration: urgent refresh, then round-robin clients, then background refresh
  always_comb begin
    sel_s = SRC_NONE;
    if (ref_debt >= 4'(URGENT)) begin
      sel_s = SRC_REF;
    end else if (req0 && req1) begin
      sel_s = last_grant_r ? SRC_C0 : SRC_C1;
    end else if (req0) begin
      sel_s = SRC_C0;
    end else if (req1) begin
      sel_s = SRC_C1;
    end else if (ref_debt != 4'd0) begin
      sel_s = SRC_REF;
    end else begin
      sel_s = SRC_NONE;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sel_s != SRC_NONE) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_ack || abort_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered sequencer attributes, client completion pulses and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req      <= 1'b0;
      mem_ref      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 16'd0;
      mem_wdata    <= 8'd0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata0       <= 8'd0;
      rdata1       <= 8'd0;
      err          <= 1'b0;
      grant_r      <= SRC_NONE;
      last_grant_r <= 1'b1;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err  <= 1'b0;
      case (state_r)
        IDLE: begin
          grant_r <= sel_s;
          case (sel_s)
            SRC_C0: begin
              mem_req      <= 1'b1;
              mem_ref      <= 1'b0;
              mem_we       <= we0;
              mem_addr     <= addr0;
              mem_wdata    <= wdata0;
              last_grant_r <= 1'b0;
            end
            SRC_C1: begin
              mem_req      <= 1'b1;
              mem_ref      <= 1'b0;
              mem_we       <= we1;
              mem_addr     <= addr1;
              mem_wdata    <= wdata1;
              last_grant_r <= 1'b1;
            end
            SRC_REF: begin
              mem_req   <= 1'b1;
              mem_ref   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= 16'd0;
              mem_wdata <= 8'd0;
            end
            default: mem_req <= 1'b0;
          endcase
        end
        BUSY: begin
          if (mem_ack || abort_s) begin
            mem_req <= 1'b0;
            err     <= abort_s;
            ack0    <= (grant_r == SRC_C0);
            ack1    <= (grant_r == SRC_C1);
            if ((grant_r == SRC_C0) && (abort_s || !mem_we)) begin
              rdata0 <= abort_s ? 8'hFF : mem_rdata;
            end
            if ((grant_r == SRC_C1) && (abort_s || !mem_we)) begin
              rdata1 <= abort_s ? 8'hFF : mem_rdata;
            end
          end
        end
        DONE:    mem_req <= 1'b0;
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_access_arbiter.sv
// Bench for dram_access_arbiter: arbitration vector table, hand-written refresh/reset/timeout
// sequences, then randomized traffic checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_dram_access_arbiter;
  localparam int REF_INTERVAL = 156;
  localparam int DEBT_MAX     = 8;
  localparam int URGENT       = 4;
  localparam int TIMEOUT      = 64;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1, cfg_we = 1'b0;
  logic [7:0]  cfg_wdata = 8'd0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = 16'd0, addr1 = 16'd0;
  logic [7:0]  wdata0 = 8'd0, wdata1 = 8'd0;
  logic        ack0, ack1, mem_req, mem_ref, mem_we, ref_ovf, err;
  logic [7:0]  rdata0, rdata1, mem_wdata;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'd0;
  logic [3:0]  ref_debt;

  always #5 clk = ~clk;

  dram_access_arbiter dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_req(mem_req), .mem_ref(mem_ref), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ref_debt(ref_debt), .ref_ovf(ref_ovf), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; cfg_we = 1'b0; mem_ack = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic set_interval(input logic [7:0] v);
    cfg_we = 1'b1; cfg_wdata = v;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic wait_mem_req(input string name);
    int n = 0;
    while (mem_req !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({name, "_req_seen"}, int'(mem_req), 1);
  endtask

  // Answer the current access after dly cycles; returns in the completion (ack) cycle.
  task automatic serve(input int dly, input logic [7:0] rd);
    repeat (dly) step();
    mem_ack = 1'b1; mem_rdata = rd;
    step();
    mem_ack = 1'b0;
  endtask

  // ---------------- reference model (transaction level) ----------------
  int m_state, m_owner, m_last, m_debt, m_interval, m_tick_at, m_wait, mcyc;
  bit m_ovf;
  logic e_req, e_ref, e_we, e_ack0, e_ack1, e_err, e_rdv;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata, e_rd0, e_rd1;

  task automatic model_step();
    bit tick, start, abort;
    int pick, nd;
    mcyc++;
    e_ack0 = 1'b0; e_ack1 = 1'b0; e_err = 1'b0; e_rdv = 1'b0;
    if (rst) begin
      m_state = 0; m_last = 1; m_debt = 0; m_ovf = 1'b0; e_req = 1'b0; e_ref = 1'b0;
      m_interval = REF_INTERVAL; m_tick_at = mcyc + REF_INTERVAL;
      return;
    end
    tick = (m_interval != 0) && (mcyc == m_tick_at);
    start = 1'b0;
    pick = -1;
    if (m_state == 0) begin
      if (m_debt >= URGENT) pick = 2;
      else if (req0 && req1) pick = (m_last == 1) ? 0 : 1;
      else if (req0) pick = 0;
      else if (req1) pick = 1;
      else if (m_debt > 0) pick = 2;
      if (pick >= 0) begin
        m_owner = pick; m_state = 1; m_wait = 0;
        e_req = 1'b1; e_ref = (pick == 2); start = (pick == 2);
        if (pick == 0) begin e_we = we0; e_addr = addr0; e_wdata = wdata0; m_last = 0; end
        if (pick == 1) begin e_we = we1; e_addr = addr1; e_wdata = wdata1; m_last = 1; end
      end
    end else if (m_state == 1) begin
      m_wait++;
      if (mem_ack || (TO_EN && m_wait == TIMEOUT)) begin
        abort = !mem_ack;
        e_req = 1'b0; e_err = abort; m_state = 2;
        e_rdv = abort || !e_we;
        if (m_owner == 0) begin e_ack0 = 1'b1; e_rd0 = abort ? 8'hFF : mem_rdata; end
        if (m_owner == 1) begin e_ack1 = 1'b1; e_rd1 = abort ? 8'hFF : mem_rdata; end
      end
    end else begin
      m_state = 0;
    end
    nd = m_debt + int'(tick) - int'(start);
    if (nd > DEBT_MAX) begin nd = DEBT_MAX; m_ovf = 1'b1; end
    m_debt = nd;
    if (cfg_we) begin
      m_ovf = 1'b0; m_interval = cfg_wdata; m_tick_at = mcyc + int'(cfg_wdata);
    end else if (tick) begin
      m_tick_at = mcyc + m_interval;
    end
  endtask

  task automatic model_compare();
    chk("r_mem_req", int'(mem_req), int'(e_req));
    if (e_req) begin
      chk("r_mem_ref", int'(mem_ref), int'(e_ref));
      if (!e_ref) begin
        chk("r_mem_we", int'(mem_we), int'(e_we));
        chk("r_mem_addr", int'(mem_addr), int'(e_addr));
        if (e_we) chk("r_mem_wdata", int'(mem_wdata), int'(e_wdata));
      end
    end
    chk("r_ack0", int'(ack0), int'(e_ack0));
    chk("r_ack1", int'(ack1), int'(e_ack1));
    if (e_ack0 && e_rdv) chk("r_rdata0", int'(rdata0), int'(e_rd0));
    if (e_ack1 && e_rdv) chk("r_rdata1", int'(rdata1), int'(e_rd1));
    chk("r_debt", int'(ref_debt), m_debt);
    chk("r_ovf", int'(ref_ovf), int'(m_ovf));
    chk("r_err", int'(err), int'(e_err));
  endtask

  // ---------------- directed arbitration vectors ----------------
  typedef struct {
    bit r0, r1, w0, w1;
    logic [15:0] a0, a1;
    logic [7:0] d0, d1;
    int dly;
    logic [7:0] rd;
    int own;
    logic [15:0] xaddr;
    bit xwe;
    logic [7:0] xwdata, xrd;
  } vec_t;
  vec_t vt[6];

  initial begin
    int t0, tp, n, acks;
    bit saw8;
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h4321, 8'h00, 8'h00, 3, 8'hA5, 0, 16'h1234, 1'b0, 8'h00, 8'hA5};
    vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0AAA, 16'hBEEF, 8'h00, 8'h3C, 1, 8'h99, 1, 16'hBEEF, 1'b1, 8'h3C, 8'h00};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h00FF, 8'h00, 8'h00, 0, 8'h5A, 1, 16'h00FF, 1'b0, 8'h00, 8'h5A};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h7FFF, 8'hC3, 8'h00, 2, 8'h11, 0, 16'h8000, 1'b1, 8'hC3, 8'h00};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 8'h00, 8'h00, 5, 8'h81, 0, 16'hFFFF, 1'b0, 8'h00, 8'h81};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'hFFFE, 8'h00, 8'h00, 2, 8'hE7, 1, 16'hFFFE, 1'b0, 8'h00, 8'hE7};

    // Reset values
    do_reset();
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_mem_ref", int'(mem_ref), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_acks", int'({ack0, ack1}), 0);
    chk("rst_rdata", int'({rdata0, rdata1}), 0);
    chk("rst_debt", int'(ref_debt), 0);
    chk("rst_ovf_err", int'({ref_ovf, err}), 0);

    // Simultaneous requests after reset: client 0 first, then client 1
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 16'h1111; addr1 = 16'h2222;
    wait_mem_req("tie0");
    chk("tie0_addr", int'(mem_addr), 16'h1111);
    serve(3, 8'h11);
    chk("tie0_ack", int'({ack0, ack1}), 2'b10);
    chk("tie0_rdata", int'(rdata0), 8'h11);
    req0 = 1'b0;
    wait_mem_req("tie1");
    chk("tie1_addr", int'(mem_addr), 16'h2222);
    serve(3, 8'h22);
    chk("tie1_ack", int'({ack0, ack1}), 2'b01);
    chk("tie1_rdata", int'(rdata1), 8'h22);
    req1 = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin step(); acks += int'(ack0) + int'(ack1) + int'(mem_req); end
    chk("tie_no_extra", acks, 0);

    // Round-robin vector table with refresh disabled
    do_reset();
    set_interval(8'd0);
    for (int i = 0; i < 6; i++) begin
      req0 = vt[i].r0; req1 = vt[i].r1; we0 = vt[i].w0; we1 = vt[i].w1;
      addr0 = vt[i].a0; addr1 = vt[i].a1; wdata0 = vt[i].d0; wdata1 = vt[i].d1;
      wait_mem_req("vec");
      chk("vec_ref", int'(mem_ref), 0);
      chk("vec_addr", int'(mem_addr), int'(vt[i].xaddr));
      chk("vec_we", int'(mem_we), int'(vt[i].xwe));
      if (vt[i].xwe) chk("vec_wdata", int'(mem_wdata), int'(vt[i].xwdata));
      serve(vt[i].dly, vt[i].rd);
      chk("vec_ack0", int'(ack0), int'(vt[i].own == 0));
      chk("vec_ack1", int'(ack1), int'(vt[i].own == 1));
      if (!vt[i].xwe) chk("vec_rdata", int'((vt[i].own == 0) ? rdata0 : rdata1), int'(vt[i].xrd));
      req0 = 1'b0; req1 = 1'b0;
      step(); step();
      chk("vec_no_regrant", int'(mem_req), 0);
    end

    // Periodic refresh every 10 cycles, debt repaid after each
    do_reset();
    set_interval(8'd10);
    t0 = cyc;
    wait_mem_req("ref10");
    chk("ref10_first", cyc - t0, 11);
    for (int k = 0; k < 3; k++) begin
      tp = cyc;
      chk("ref10_is_ref", int'(mem_ref), 1);
      chk("ref10_debt_start", int'(ref_debt), 0);
      serve(1, 8'h00);
      chk("ref10_no_ack", int'({ack0, ack1}), 0);
      step();
      chk("ref10_debt_after", int'(ref_debt), 0);
      wait_mem_req("ref10n");
      chk("ref10_period", cyc - tp, 10);
    end

    // Debt saturation under a stalled refresh, then urgent refresh beats client 0
    do_reset();
    set_interval(8'd2);
    wait_mem_req("stall");
    chk("stall_is_ref", int'(mem_ref), 1);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h5555;
    n = 0; saw8 = 1'b0;
    while (!ref_ovf && n < 60) begin
      step(); n++;
      if (ref_debt == 4'd8 && !ref_ovf) saw8 = 1'b1;
    end
    chk("stall_ovf", int'(ref_ovf), 1);
    chk("stall_debt", int'(ref_debt), 8);
    chk("stall_saw8_first", int'(saw8), 1);
    serve(0, 8'h00);
    chk("stall_ref_no_ack", int'({ack0, ack1}), 0);
    step(); step();
    chk("urgent_req", int'(mem_req), 1);
    chk("urgent_is_ref", int'(mem_ref), 1);
    set_interval(8'd0);
    chk("cfg_clears_ovf", int'(ref_ovf), 0);
    rst = 1'b1; req0 = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_busy_req", int'(mem_req), 0);
    chk("rst_busy_debt", int'(ref_debt), 0);

    // Reset during a client write discards it without ack
    set_interval(8'd0);
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'hABCD; wdata1 = 8'h77;
    wait_mem_req("rstc");
    chk("rstc_addr", int'(mem_addr), 16'hABCD);
    step();
    rst = 1'b1; req1 = 1'b0;
    step();
    rst = 1'b0;
    chk("rstc_outs", int'({mem_req, mem_ref, mem_we, ack0, ack1, err}), 0);
    chk("rstc_addr0", int'(mem_addr), 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin step(); acks += int'(ack0) + int'(ack1); end
    chk("rstc_no_ack", acks, 0);

`ifdef ARB_TIMEOUT_EN
    // Watchdog abort of a client 1 read
    do_reset();
    set_interval(8'd0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0F0F;
    wait_mem_req("to");
    t0 = cyc; n = 0;
    while (!err && n < 120) begin step(); n++; end
    chk("to_err_gap", cyc - t0, TIMEOUT);
    chk("to_ack1", int'(ack1), 1);
    chk("to_rdata1", int'(rdata1), 8'hFF);
    req1 = 1'b0;
    step();
    chk("to_err_pulse", int'(err), 0);
`endif

    // Randomized traffic against the reference model
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; cfg_we = 1'b0; mem_ack = 1'b0;
    model_step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      cfg_we = ($urandom_range(0, 149) == 0);
      cfg_wdata = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
      if (ack0) req0 = 1'b0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        addr0 = 16'($urandom_range(0, 65535)); wdata0 = 8'($urandom_range(0, 255));
      end
      if (ack1) req1 = 1'b0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        addr1 = 16'($urandom_range(0, 65535)); wdata1 = 8'($urandom_range(0, 255));
      end
      if (mem_ack) mem_ack = 1'b0;
      else if (mem_req && $urandom_range(0, 2) == 0) begin
        mem_ack = 1'b1; mem_rdata = 8'($urandom_range(0, 255));
      end
      model_step();
      step();
      model_compare();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
